embertrail_dmem_arbiter: RTL



---
 rtl/embertrail_dmem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/embertrail_dmem_arbiter.sv
// Sequences the two per-slot data-memory requests of the dual-issue control unit onto one
// single-ported synchronous memory, slot 1 first. Optional feature: EMBERTRAIL_DMEM_WRITE_MERGE_EN.
module embertrail_dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iReq1,
  input  logic              iReq2,
  input  logic              iRW1,
  input  logic              iRW2,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [ADDR_W-1:0] iAddr2,
  input  logic [DATA_W-1:0] iWData1,
  input  logic [DATA_W-1:0] iWData2,
  output logic [DATA_W-1:0] oRData1,
  output logic [DATA_W-1:0] oRData2,
  output logic              oBusy,
  output logic              oDone,
  output logic              oMemEn,
  output logic              oMemRW,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC1 = 3'd1,
    ACC2 = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Slot-indexed views of the request inputs; index 0 is slot 1.
  logic [1:0]             slot_req;
  logic [1:0]             slot_rw;
  logic [1:0][ADDR_W-1:0] slot_addr;
  logic [1:0][DATA_W-1:0] slot_wdata;

  logic [1:0]             pend_q;
  logic [1:0]             rw_q;
  logic [1:0][ADDR_W-1:0] addr_q;
  logic [1:0][DATA_W-1:0] wdata_q;
  logic [1:0][DATA_W-1:0] rdata_q;

  logic       accept;
  logic       merge;
  logic [1:0] accept_pend;
  logic [1:0] in_acc;

  assign slot_req   = {iReq2, iReq1};
  assign slot_rw    = {iRW2, iRW1};
  assign slot_addr  = {iAddr2, iAddr1};
  assign slot_wdata = {iWData2, iWData1};

  assign accept = (state_reg == IDLE) && (|slot_req);

`ifdef EMBERTRAIL_DMEM_WRITE_MERGE_EN
  // Two writes to one address: the later instruction (slot 2) wins, so slot 1 is dropped.
  assign merge = iReq1 & iReq2 & iRW1 & iRW2 & (iAddr1 == iAddr2);
`else
  assign merge = 1'b0;
`endif

  assign accept_pend = {iReq2, iReq1 & ~merge};
  assign in_acc      = {state_reg == ACC2, state_reg == ACC1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic              pend_reg;
      logic              rw_reg;
      logic              cap_reg;
      logic [ADDR_W-1:0] addr_reg;
      logic [DATA_W-1:0] wdata_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
          pend_reg  <= 1'b0;
          rw_reg    <= 1'b0;
          cap_reg   <= 1'b0;
          addr_reg  <= '0;
          wdata_reg <= '0;
          rdata_reg <= '0;
        end else begin
          if (accept) begin
            pend_reg  <= accept_pend[gi];
            rw_reg    <= slot_rw[gi];
            addr_reg  <= slot_addr[gi];
            wdata_reg <= slot_wdata[gi];
          end
          // Memory returns read data one cycle after the strobe; capture at the end of that cycle.
          cap_reg <= in_acc[gi] & ~rw_reg;
          if (cap_reg) begin
            rdata_reg <= iMemRData;
          end
        end
      end

      assign pend_q[gi]  = pend_reg;
      assign rw_q[gi]    = rw_reg;
      assign addr_q[gi]  = addr_reg;
      assign wdata_q[gi] = wdata_reg;
      assign rdata_q[gi] = rdata_reg;
    end
  endgenerate

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    oMemEn     = 1'b0;
    oMemRW     = 1'b0;
    oMemAddr   = '0;
    oMemWData  = '0;
    oDone      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = accept_pend[0] ? ACC1 : ACC2;
        end
      end
      ACC1: begin
        oMemEn     = 1'b1;
        oMemRW     = rw_q[0];
        oMemAddr   = addr_q[0];
        oMemWData  = rw_q[0] ? wdata_q[0] : '0;
        state_next = pend_q[1] ? ACC2 : CAP;
      end
      ACC2: begin
        oMemEn     = 1'b1;
        oMemRW     = rw_q[1];
        oMemAddr   = addr_q[1];
        oMemWData  = rw_q[1] ? wdata_q[1] : '0;
        state_next = CAP;
      end
      CAP: begin
        state_next = DONE;
      end
      DONE: begin
        oDone      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign oBusy   = (state_reg != IDLE);
  assign oRData1 = rdata_q[0];
  assign oRData2 = rdata_q[1];

endmodule
